// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count-sequence checker.
package count_checker_pkg;

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StSync     = 2'd1,
        StLocked   = 2'd2
    } checker_state_e;

    localparam int unsigned UioValid     = 0;
    localparam int unsigned UioDir       = 1;
    localparam int unsigned UioClear     = 2;
    localparam int unsigned UioSel       = 3;
    localparam int unsigned UioLocked    = 4;
    localparam int unsigned UioErrSticky = 5;
    localparam int unsigned UioErrPulse  = 6;
    localparam int unsigned UioWrapSeen  = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    // Next value of an 8-bit counter stepping by `step` in direction `dir` (1 = down).
    function automatic logic [7:0] step_next(input logic [7:0] value, input logic dir,
                                             input logic [7:0] step);
        return dir ? (value - step) : (value + step);
    endfunction

endpackage

// File: rtl/count_step_predictor.sv
// Holds the expected next count value and flags matches and boundary-crossing steps.
module count_step_predictor
    import count_checker_pkg::*;
#(
    parameter logic [7:0] STEP = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample,
    input  logic       dir,
    input  logic       load,
    input  logic       advance,
    output logic       match,
    output logic       wrap
);

    logic [7:0] exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 8'h00;
        end else if (load) begin
            exp_q <= step_next(sample, dir, STEP);
        end else if (advance) begin
            exp_q <= step_next(exp_q, dir, STEP);
        end
    end

    assign match = (sample == exp_q);
    // A matching sample crossed FF<->00 when the previous value sat within STEP of the edge.
    assign wrap  = match && (dir ? (sample > (8'hFF - STEP)) : (sample < STEP));

endmodule

// File: rtl/tt_um_count_checker.sv
// Checks that an observed 8-bit counter advances by +/-STEP; tracks lock, errors and wraps.
module tt_um_count_checker
    import count_checker_pkg::*;
#(
    parameter int unsigned SYNC_MATCHES = 4,
    parameter logic [7:0]  STEP         = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] SyncTarget = SYNC_MATCHES[3:0];

    logic       unused_uio;
    assign unused_uio = ^uio_in[7:4];

    logic       ena_q, valid_q, dir_q, clear_q, sel_q;
    logic [7:0] sample_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q    <= 1'b0;
            sample_q <= 8'h00;
            valid_q  <= 1'b0;
            dir_q    <= 1'b0;
            clear_q  <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            ena_q    <= ena;
            sample_q <= ui_in;
            valid_q  <= uio_in[UioValid];
            dir_q    <= uio_in[UioDir];
            clear_q  <= uio_in[UioClear];
            sel_q    <= uio_in[UioSel];
        end
    end

    checker_state_e state_q, state_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic       dir_ref_q, dir_ref_d;
    logic [7:0] err_cnt_q, err_cnt_d, last_bad_q, last_bad_d;
    logic       err_sticky_q, err_sticky_d, wrap_seen_q, wrap_seen_d;
    logic       err_pulse_q, err_pulse_d, locked_q, locked_d, sel_out_q;
    logic       load, advance, match, wrap;

    count_step_predictor #(
        .STEP(STEP)
    ) u_predictor (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sample_q),
        .dir    (dir_q),
        .load   (load),
        .advance(advance),
        .match  (match),
        .wrap   (wrap)
    );

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        dir_ref_d    = dir_ref_q;
        err_cnt_d    = err_cnt_q;
        last_bad_d   = last_bad_q;
        err_sticky_d = err_sticky_q;
        wrap_seen_d  = wrap_seen_q;
        err_pulse_d  = 1'b0;
        load         = 1'b0;
        advance      = 1'b0;

        if (!ena_q) begin
            state_d = StUnlocked;
        end else begin
            if (clear_q) begin
                err_cnt_d    = 8'h00;
                last_bad_d   = 8'h00;
                err_sticky_d = 1'b0;
                wrap_seen_d  = 1'b0;
            end
            if (valid_q) begin
                dir_ref_d = dir_q;
                unique case (state_q)
                    StUnlocked: begin
                        load        = 1'b1;
                        match_cnt_d = 4'd0;
                        state_d     = StSync;
                    end
                    StSync: begin
                        if (dir_q == dir_ref_q && match) begin
                            advance     = 1'b1;
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_d == SyncTarget) state_d = StLocked;
                        end else begin
                            load        = 1'b1;
                            match_cnt_d = 4'd0;
                        end
                    end
                    StLocked: begin
                        if (dir_q != dir_ref_q) begin
                            load        = 1'b1;
                            match_cnt_d = 4'd0;
                            state_d     = StSync;
                        end else if (match) begin
                            advance = 1'b1;
                            if (wrap) wrap_seen_d = 1'b1;
                        end else begin
                            // Mismatch is applied after clear so it survives a same-cycle clear.
                            load         = 1'b1;
                            err_pulse_d  = 1'b1;
                            err_sticky_d = 1'b1;
                            last_bad_d   = sample_q;
                            if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
                        end
                    end
                    default: state_d = StUnlocked;
                endcase
            end
        end
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StUnlocked;
            match_cnt_q  <= 4'd0;
            dir_ref_q    <= 1'b0;
            err_cnt_q    <= 8'h00;
            last_bad_q   <= 8'h00;
            err_sticky_q <= 1'b0;
            wrap_seen_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            locked_q     <= 1'b0;
            sel_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            dir_ref_q    <= dir_ref_d;
            err_cnt_q    <= err_cnt_d;
            last_bad_q   <= last_bad_d;
            err_sticky_q <= err_sticky_d;
            wrap_seen_q  <= wrap_seen_d;
            err_pulse_q  <= err_pulse_d;
            locked_q     <= locked_d;
            sel_out_q    <= sel_q;
        end
    end

    always_comb begin
        uio_out               = 8'h00;
        uio_out[UioLocked]    = locked_q;
        uio_out[UioErrSticky] = err_sticky_q;
        uio_out[UioErrPulse]  = err_pulse_q;
        uio_out[UioWrapSeen]  = wrap_seen_q;
    end

    assign uo_out = sel_out_q ? last_bad_q : err_cnt_q;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Directed and randomized checks of tt_um_count_checker against a sample-level reference model.
module tb_tt_um_count_checker;

    localparam int unsigned SyncMatches = 4;
    localparam int          Step        = 1;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_count_checker #(
        .SYNC_MATCHES(SyncMatches),
        .STEP        (8'(Step))
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: pins seen at the previous edge, and the resulting visible status.
    bit pv_ena, pv_valid, pv_dir, pv_clear, pv_sel;
    int pv_s;
    int m_mode;   // 0 searching, 1 acquiring, 2 locked
    int m_exp, m_streak, m_prev, m_err, m_bad;
    bit m_dir, m_sticky, m_wrap, m_pulse, m_sel;

    function automatic int nxt(input int v, input bit d);
        return d ? (v - Step + 256) % 256 : (v + Step) % 256;
    endfunction

    task automatic model_reset();
        {pv_ena, pv_valid, pv_dir, pv_clear, pv_sel} = '0;
        pv_s = 0; m_mode = 0; m_exp = 0; m_streak = 0; m_prev = 0; m_err = 0; m_bad = 0;
        {m_dir, m_sticky, m_wrap, m_pulse, m_sel} = '0;
    endtask

    task automatic model_step();
        m_sel   = pv_sel;
        m_pulse = 0;
        if (!pv_ena) begin
            m_mode = 0;
            return;
        end
        if (pv_clear) begin
            m_err = 0; m_bad = 0; m_sticky = 0; m_wrap = 0;
        end
        if (!pv_valid) return;
        if (m_mode == 0 || pv_dir != m_dir) begin
            m_mode = 1; m_streak = 0;
        end else if (pv_s == m_exp) begin
            if (m_mode == 1) begin
                m_streak++;
                if (m_streak == SyncMatches) m_mode = 2;
            end else if (pv_dir ? (m_prev < Step) : (m_prev + Step > 255)) begin
                m_wrap = 1;
            end
        end else if (m_mode == 2) begin
            m_err    = (m_err < 255) ? m_err + 1 : 255;
            m_sticky = 1; m_bad = pv_s; m_pulse = 1;
        end else begin
            m_streak = 0;
        end
        m_exp = nxt(pv_s, pv_dir);
        m_dir = pv_dir;
        m_prev = pv_s;
    endtask

    function automatic logic [23:0] model_bus();
        logic [7:0] st;
        st = {m_wrap, m_pulse, m_sticky, (m_mode == 2), 4'b0000};
        return {8'(m_sel ? m_bad : m_err), st, 8'hF0};
    endfunction

    // Per-cycle comparison of every output against the model.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step();
                pv_ena = ena; pv_s = int'(ui_in); pv_valid = uio_in[0];
                pv_dir = uio_in[1]; pv_clear = uio_in[2]; pv_sel = uio_in[3];
            end
            #1;
            checks++;
            if ({uo_out, uio_out, uio_oe} !== model_bus()) begin
                errors++;
                $display("FAIL cycle_model @%0t: got %h expected %h", $time,
                         {uo_out, uio_out, uio_oe}, model_bus());
            end
        end
    end

    task automatic put(input logic [7:0] s, input bit v, input bit d, input bit c, input bit sel);
        ui_in  = s;
        uio_in = {4'b0000, sel, c, d, v};
        @(negedge clk);
        if (uio_out[6]) pulses++;
    endtask

    logic [7:0] prev, val, g;
    bit         e, d, sel_r;

    initial begin
        repeat (2) @(negedge clk);
        check8("reset_uo", uo_out, 8'h00);
        check8("reset_uio_out", uio_out, 8'h00);
        check8("reset_uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        ena   = 1'b1;

        for (int i = 0; i < 16; i++) begin
            put(8'(i), 1, 0, 0, 0);
            if (i == 4) check8("lock_not_early", 8'(uio_out[4]), 8'd0);
            if (i == 5) check8("lock_rises", 8'(uio_out[4]), 8'd1);
        end
        check8("up_count_no_err", uo_out, 8'h00);

        pulses = 0;
        put(8'h10, 1, 0, 0, 0);
        put(8'h11, 1, 0, 0, 0);
        put(8'h20, 1, 0, 0, 0);
        put(8'h21, 1, 0, 0, 1);
        put(8'h22, 1, 0, 0, 1);
        put(8'h23, 1, 0, 0, 1);
        check8("jump_one_pulse", 8'(pulses), 8'd1);
        check8("jump_last_bad", uo_out, 8'h20);
        check8("jump_still_locked", 8'(uio_out[4]), 8'd1);
        put(8'h24, 1, 0, 0, 0);
        put(8'h25, 1, 0, 0, 0);
        check8("jump_err_cnt", uo_out, 8'h01);

        put(8'hF0, 1, 0, 0, 0);
        for (int i = 8'hF1; i <= 8'hFB; i++) put(8'(i), 1, 0, 0, 0);
        put(8'hFC, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) put(8'(8'hFD + i), 1, 0, 0, 0);
        check8("wrap_up_flags", uio_out, 8'h90);
        check8("wrap_up_no_err", uo_out, 8'h00);

        pulses = 0;
        put(8'h02, 1, 1, 0, 0);
        put(8'h01, 1, 1, 0, 0);
        check8("dir_change_unlock", 8'(uio_out[4]), 8'd0);
        for (int i = 0; i < 6; i++) put(8'(8'h00 - i), 1, 1, 0, 0);
        check8("down_relock", 8'(uio_out[4]), 8'd1);
        check8("down_no_pulse", 8'(pulses), 8'd0);
        check8("down_no_err", uo_out, 8'h00);

        // Last down sample was 0xFB, so the checker now expects 0xFA.
        prev   = 8'hFB;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            do val = 8'($urandom); while (val == 8'(prev - 8'd1));
            put(val, 1, 1, 0, 0);
            prev = val;
        end
        put(8'h00, 0, 1, 0, 0);
        put(8'h00, 0, 1, 0, 0);
        check8("sat_pulse_count", 8'(pulses == 300), 8'd1);
        check8("sat_err_cnt", uo_out, 8'hFF);
        check8("sat_sticky", 8'(uio_out[5]), 8'd1);

        val = prev + 8'h40;
        put(val, 1, 1, 1, 0);
        put(8'h00, 0, 1, 0, 0);
        put(8'h00, 0, 1, 0, 0);
        check8("clear_vs_mismatch_cnt", uo_out, 8'h01);
        check8("clear_vs_mismatch_sticky", 8'(uio_out[5]), 8'd1);
        put(8'h00, 0, 1, 1, 0);
        put(8'h00, 0, 1, 0, 0);
        put(8'h00, 0, 1, 0, 0);
        check8("clear_alone_cnt", uo_out, 8'h00);
        check8("clear_alone_flags", uio_out, 8'h10);

        put(val + 8'h40, 1, 1, 0, 0);
        put(8'h00, 0, 1, 0, 0);
        put(8'h00, 0, 1, 0, 0);
        ena = 1'b0;
        put(8'h00, 0, 1, 0, 0);
        check8("ena_low_first_clock", 8'(uio_out[4]), 8'd1);
        put(8'h00, 0, 1, 0, 0);
        check8("ena_low_unlock", 8'(uio_out[4]), 8'd0);
        check8("ena_low_err_held", uo_out, 8'h01);

        ena = 1'b1;
        for (int i = 0; i < 4; i++) put(8'(i), 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check8("async_reset_uo", uo_out, 8'h00);
        check8("async_reset_uio_out", uio_out, 8'h00);
        check8("async_reset_uio_oe", uio_oe, 8'hF0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        g = 8'($urandom); e = 1; d = 0; sel_r = 0;
        for (int n = 0; n < 3000; n++) begin
            if (e ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 3) == 0)) e = ~e;
            ena = e;
            if ($urandom_range(0, 39) == 0) d = ~d;
            if ($urandom_range(0, 9) == 0) sel_r = ~sel_r;
            if ($urandom_range(0, 29) == 0) g = 8'($urandom);
            else g = d ? g - 8'(Step) : g + 8'(Step);
            put(g, $urandom_range(0, 9) < 9, d, $urandom_range(0, 59) == 0, sel_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
